// File: rtl/audio_pulse_multi.sv
// Multi-channel pulse generator that turns level toggles into 64-bit shifter command words.
// Optional saturating overrun counter is built when AUDIO_PULSE_OVERRUN_EN is defined.
module audio_pulse_multi #(
   parameter int          NUM_CH = 4,
   parameter int          CNT_W  = 10,
   parameter logic [7:0]  VEL    = 8'hFF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [NUM_CH-1:0]       chan_en,
   input  logic [NUM_CH*CNT_W-1:0] half_period,
   input  logic                    shft_ready,
   output logic                    shft_load,
   output logic [63:0]             shft_data,
   output logic [NUM_CH-1:0]       level,
   output logic [7:0]              overrun_cnt
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [CNT_W-1:0]  cnt     [NUM_CH];
   logic [CNT_W-1:0]  cnt_nxt [NUM_CH];
   logic [NUM_CH-1:0] level_nxt;
   logic [NUM_CH-1:0] evt;
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] pend_lvl;
   logic [NUM_CH-1:0] gnt_mask;
   logic [IDX_W-1:0]  last_g;
   logic [IDX_W-1:0]  gnt_idx;
   logic              gnt_found;
   logic              grant;

   // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin : chan_logic
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_nxt[i]   = cnt[i];
         level_nxt[i] = level[i];
         evt[i]       = 1'b0;
         if (en) begin
            if (chan_en[i]) begin
               if (half_period[i*CNT_W +: CNT_W] != '0) begin
                  // >= lets a shrunk half-period toggle on the very next enabled cycle
                  if (cnt[i] >= half_period[i*CNT_W +: CNT_W] - CNT_W'(1)) begin
                     cnt_nxt[i]   = '0;
                     level_nxt[i] = ~level[i];
                     evt[i]       = 1'b1;
                  end else begin
                     cnt_nxt[i] = cnt[i] + CNT_W'(1);
                  end
               end
            end else begin
               cnt_nxt[i] = '0;
               if (level[i]) begin
                  level_nxt[i] = 1'b0;
                  evt[i]       = 1'b1;
               end
            end
         end
      end
   end

   // Round-robin search starts one past the last granted channel.
   always_comb begin : arbiter
      int idx;
      idx       = 0;
      gnt_idx   = last_g;
      gnt_found = 1'b0;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = int'(last_g) + k;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!gnt_found && pending[IDX_W'(idx)]) begin
            gnt_found = 1'b1;
            gnt_idx   = IDX_W'(idx);
         end
      end
      grant    = shft_ready && gnt_found && !shft_load;
      gnt_mask = grant ? (NUM_CH'(1) << gnt_idx) : '0;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the counter array is reset explicitly; toggle timing depends on it starting at zero.
         for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
         level     <= '0;
         pending   <= '0;
         pend_lvl  <= '0;
         shft_load <= 1'b0;
         shft_data <= '0;
         last_g    <= IDX_W'(NUM_CH - 1);
      end else begin
         for (int i = 0; i < NUM_CH; i++) cnt[i] <= cnt_nxt[i];
         level     <= level_nxt;
         shft_load <= grant;
         if (grant) begin
            shft_data <= {4'h9, 4'(gnt_idx), 48'h0, pend_lvl[gnt_idx] ? VEL : 8'h00};
            last_g    <= gnt_idx;
         end
         // A same-edge event on the granted channel re-arms it with the new level.
         pending  <= (pending & ~gnt_mask) | evt;
         pend_lvl <= (pend_lvl & ~evt) | (level_nxt & evt);
      end
   end

`ifdef AUDIO_PULSE_OVERRUN_EN
   logic [3:0] ovr_n;
   logic [8:0] ovr_sum;

   always_comb begin
      ovr_n = '0;
      for (int i = 0; i < NUM_CH; i++) ovr_n = ovr_n + 4'(evt[i] & pending[i]);
      ovr_sum = {1'b0, overrun_cnt} + 9'(ovr_n);
   end

   always_ff @(posedge clk) begin
      if (rst) overrun_cnt <= 8'h00;
      else     overrun_cnt <= ovr_sum[8] ? 8'hFF : ovr_sum[7:0];
   end
`else
   assign overrun_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_audio_pulse_multi.sv
// Self-checking bench for audio_pulse_multi: directed scenarios plus random traffic against a cycle model.
module tb_audio_pulse_multi;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 10;
   localparam logic [7:0] VEL = 8'hFF;

   logic                    clk = 1'b0;
   logic                    rst, en, shft_ready;
   logic [NUM_CH-1:0]       chan_en;
   logic [CNT_W-1:0]        hp [NUM_CH];
   logic [NUM_CH*CNT_W-1:0] half_period;
   logic                    shft_load;
   logic [63:0]             shft_data;
   logic [NUM_CH-1:0]       level;
   logic [7:0]              overrun_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model state
   int       m_cnt [NUM_CH];
   bit       m_lvl [NUM_CH];
   bit       m_pend[NUM_CH];
   bit       m_pl  [NUM_CH];
   int       m_last, m_ovr;
   bit       m_load;
   bit [63:0] m_data;

   int grants[$];

   always #5 clk = ~clk;

   always_comb begin
      half_period = '0;
      for (int i = 0; i < NUM_CH; i++) half_period[i*CNT_W +: CNT_W] = hp[i];
   end

   audio_pulse_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .VEL(VEL)) dut (
      .clk(clk), .rst(rst), .en(en), .chan_en(chan_en), .half_period(half_period),
      .shft_ready(shft_ready), .shft_load(shft_load), .shft_data(shft_data),
      .level(level), .overrun_cnt(overrun_cnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock of the behavioural rules, applied to the inputs present before the edge.
   task automatic model_step();
      bit ev[NUM_CH];
      bit nl[NUM_CH];
      bit old_p[NUM_CH];
      bit any;
      int g;
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i] = 0; m_lvl[i] = 0; m_pend[i] = 0; m_pl[i] = 0;
         end
         m_last = NUM_CH - 1; m_ovr = 0; m_load = 0; m_data = '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            ev[i] = 0; nl[i] = m_lvl[i];
            if (en && chan_en[i]) begin
               if (int'(hp[i]) != 0) begin
                  if (m_cnt[i] >= int'(hp[i]) - 1) begin
                     m_cnt[i] = 0; nl[i] = !m_lvl[i]; ev[i] = 1;
                  end else m_cnt[i]++;
               end
            end else if (en) begin
               m_cnt[i] = 0;
               if (m_lvl[i]) begin nl[i] = 0; ev[i] = 1; end
            end
         end
         old_p = m_pend;
         any = 0;
         for (int i = 0; i < NUM_CH; i++) any |= m_pend[i];
         if (shft_ready && any && !m_load) begin
            g = m_last;
            do g = (g + 1) % NUM_CH; while (!m_pend[g]);
            m_data = {4'h9, 4'(g), 48'h0, m_pl[g] ? VEL : 8'h00};
            m_load = 1; m_pend[g] = 0; m_last = g;
         end else m_load = 0;
         for (int i = 0; i < NUM_CH; i++) begin
            if (ev[i]) begin
               if (old_p[i] && m_ovr < 255) m_ovr++;
               m_pend[i] = 1; m_pl[i] = nl[i];
            end
            m_lvl[i] = nl[i];
         end
      end
   endtask

   task automatic cycle();
      logic [NUM_CH-1:0] exp_lvl;
      logic [7:0]        exp_ovr;
      model_step();
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_CH; i++) exp_lvl[i] = m_lvl[i];
`ifdef AUDIO_PULSE_OVERRUN_EN
      exp_ovr = 8'(m_ovr);
`else
      exp_ovr = 8'h00;
`endif
      check("shft_load", 64'(shft_load), 64'(m_load));
      check("shft_data", shft_data, m_data);
      check("level", 64'(level), 64'(exp_lvl));
      check("overrun_cnt", 64'(overrun_cnt), 64'(exp_ovr));
      if (shft_load) grants.push_back(int'(shft_data[59:56]));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_ovr4;
      rst = 1'b1; en = 1'b0; shft_ready = 1'b0; chan_en = '0;
      for (int i = 0; i < NUM_CH; i++) hp[i] = '0;

      // reset state
      do_reset();
      check("reset_load", 64'(shft_load), 64'h0);
      check("reset_data", shft_data, 64'h0);

      // single channel, half-period 4, ready held high
      en = 1; chan_en = 4'b0001; hp[0] = 4; shft_ready = 1;
      repeat (4) cycle();
      check("hp4_first_toggle", 64'(level[0]), 64'h1);
      cycle();
      check("hp4_first_word", shft_data, 64'h9000_0000_0000_00FF);
      repeat (4) cycle();
      check("hp4_second_word", shft_data, 64'h9000_0000_0000_0000);
      repeat (8) cycle();

      // four channels in lockstep: round-robin 0,1,2,3
      do_reset();
      grants.delete();
      chan_en = 4'b1111; shft_ready = 1;
      for (int i = 0; i < NUM_CH; i++) hp[i] = 3;
      repeat (12) cycle();
      for (int k = 0; k < 4; k++)
         check($sformatf("rr_order_%0d", k), 64'(k < grants.size() ? grants[k] : 15), 64'(k));

      // ready low for 10 cycles, half-period 2
      do_reset();
      chan_en = 4'b0001; hp[0] = 2; shft_ready = 0;
      for (int i = 1; i < NUM_CH; i++) hp[i] = 0;
      repeat (10) cycle();
`ifdef AUDIO_PULSE_OVERRUN_EN
      exp_ovr4 = 8'd4;
`else
      exp_ovr4 = 8'd0;
`endif
      check("ready_low_overrun", 64'(overrun_cnt), 64'(exp_ovr4));
      shft_ready = 1;
      cycle();
      check("ready_release_load", 64'(shft_load), 64'h1);
      check("ready_release_data", shft_data, 64'h9000_0000_0000_00FF);
      cycle();
      check("ready_release_single", 64'(shft_load), 64'h0);

      // channel high then disabled: note-off
      hp[0] = 20;
      repeat (5) cycle();
      if (!level[0]) repeat (20) cycle();
      chan_en = 4'b0000;
      cycle();
      check("disable_level", 64'(level[0]), 64'h0);
      repeat (3) cycle();

      // reset with three channels pending
      do_reset();
      chan_en = 4'b0111; shft_ready = 0;
      for (int i = 0; i < NUM_CH; i++) hp[i] = 2;
      repeat (4) cycle();
      do_reset();
      check("rst_mid_load", 64'(shft_load), 64'h0);
      check("rst_mid_level", 64'(level), 64'h0);
      en = 0; shft_ready = 1;
      repeat (4) cycle();

      // half-period shrinks below the running count
      en = 1; chan_en = 4'b0001; hp[0] = 100;
      repeat (50) cycle();
      hp[0] = 5;
      cycle();
      check("shrink_toggle", 64'(level[0]), 64'h1);
      repeat (12) cycle();

      // random traffic
      for (int n = 0; n < 2000; n++) begin
         rst        = ($urandom_range(0, 199) == 0);
         en         = ($urandom_range(0, 9) != 0);
         shft_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 19) == 0) chan_en = NUM_CH'($urandom);
         if ($urandom_range(0, 29) == 0) hp[$urandom_range(0, NUM_CH-1)] = CNT_W'($urandom_range(0, 7));
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
